// File: rtl/env_adsr.sv
// ADSR envelope generator: one envelope step per sample clock, 24-bit saturating
// accumulator whose top 16 bits drive a signed 17-bit oscillator volume input.
module env_adsr (
  input  logic        clk,
  input  logic        rst,
  input  logic        gate,
  input  logic [23:0] attack_rate,
  input  logic [23:0] decay_rate,
  input  logic [15:0] sustain_level,
  input  logic [23:0] release_rate,
  output logic [16:0] volume,
  output logic        active,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  localparam logic [23:0] FULL = 24'hFFFFFF;

  state_t      st;
  logic [23:0] acc;
  logic        gate_q;
  logic        rise;
  logic        fall;
  logic [23:0] target;

  function automatic logic attack_done(input logic [23:0] a, input logic [23:0] r);
    logic [24:0] sum;
    sum = {1'b0, a} + {1'b0, r};
    return (r == 24'd0) || (sum >= {1'b0, FULL});
  endfunction

  // 26-bit signed difference so an accumulator below the sustain target still lands on it
  function automatic logic decay_done(input logic [23:0] a, input logic [23:0] r,
                                      input logic [23:0] t);
    logic signed [25:0] diff;
    diff = $signed({2'b00, a}) - $signed({2'b00, r});
    return (r == 24'd0) || (diff <= $signed({2'b00, t}));
  endfunction

  function automatic logic release_done(input logic [23:0] a, input logic [23:0] r);
    return (r == 24'd0) || (a <= r);
  endfunction

  assign rise   = gate & ~gate_q;
  assign fall   = ~gate & gate_q;
  assign target = {sustain_level, 8'h00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st     <= IDLE;
      acc    <= 24'd0;
      gate_q <= 1'b0;
    end else begin
      gate_q <= gate;
      if (rise) begin
        st <= ATTACK;
      end else if (fall && (st == ATTACK || st == DECAY || st == SUSTAIN)) begin
        st <= RELEASE;
      end else begin
        case (st)
          IDLE: acc <= 24'd0;
          ATTACK: begin
            if (attack_done(acc, attack_rate)) begin
              acc <= FULL;
              st  <= DECAY;
            end else begin
              acc <= acc + attack_rate;
            end
          end
          DECAY: begin
            if (decay_done(acc, decay_rate, target)) begin
              acc <= target;
              st  <= SUSTAIN;
            end else begin
              acc <= acc - decay_rate;
            end
          end
          SUSTAIN: acc <= target;
          RELEASE: begin
            if (release_done(acc, release_rate)) begin
              acc <= 24'd0;
              st  <= IDLE;
            end else begin
              acc <= acc - release_rate;
            end
          end
          default: begin
            acc <= 24'd0;
            st  <= IDLE;
          end
        endcase
      end
    end
  end

  assign volume = {1'b0, acc[23:8]};
  assign active = (st != IDLE);
  assign state  = st;

endmodule

// File: tb/tb_env_adsr.sv
// Bench for env_adsr: directed envelope scenarios followed by randomized gate and
// rate traffic, all checked against a level/phase reference model.
module tb_env_adsr;

  logic        clk = 1'b0;
  logic        rst;
  logic        gate;
  logic [23:0] attack_rate;
  logic [23:0] decay_rate;
  logic [15:0] sustain_level;
  logic [23:0] release_rate;
  logic [16:0] volume;
  logic        active;
  logic [2:0]  state;

  env_adsr dut (
    .clk(clk), .rst(rst), .gate(gate),
    .attack_rate(attack_rate), .decay_rate(decay_rate),
    .sustain_level(sustain_level), .release_rate(release_rate),
    .volume(volume), .active(active), .state(state)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: phase 0..4 and level as a plain integer in 1/256 volume units
  localparam longint FULL = 64'h0000_0000_00FF_FFFF;
  int     m_phase;
  longint m_lvl;
  bit     m_gq;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_lvl   = 0;
    m_gq    = 0;
  endtask

  task automatic model_edge();
    longint t;
    bit rise, fall;
    t    = longint'(sustain_level) * 256;
    rise = gate && !m_gq;
    fall = !gate && m_gq;
    if (rise) m_phase = 1;
    else if (fall && m_phase >= 1 && m_phase <= 3) m_phase = 4;
    else begin
      case (m_phase)
        0: m_lvl = 0;
        1: if (attack_rate == 0 || m_lvl + longint'(attack_rate) >= FULL) begin
             m_lvl = FULL; m_phase = 2;
           end else m_lvl = m_lvl + longint'(attack_rate);
        2: if (decay_rate == 0 || m_lvl - longint'(decay_rate) <= t) begin
             m_lvl = t; m_phase = 3;
           end else m_lvl = m_lvl - longint'(decay_rate);
        3: m_lvl = t;
        default: if (release_rate == 0 || m_lvl <= longint'(release_rate)) begin
             m_lvl = 0; m_phase = 0;
           end else m_lvl = m_lvl - longint'(release_rate);
      endcase
    end
    m_gq = gate;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".vol"}, longint'(volume), m_lvl / 256);
    check({tag, ".state"}, longint'(state), longint'(m_phase));
    check({tag, ".active"}, longint'(active), longint'(m_phase != 0));
  endtask

  // One sample edge: model advances with the inputs present at the edge, outputs checked 1 time unit later
  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  initial begin
    rst = 1'b1; gate = 1'b0;
    attack_rate = 24'h010000; decay_rate = 24'h010000;
    sustain_level = 16'h8000; release_rate = 24'h008000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    rst = 1'b0;
    tick("idle");

    // Attack ramp
    gate = 1'b1;
    tick("rise");
    check("rise_state", longint'(state), 1);
    check("rise_vol", longint'(volume), 0);
    for (int k = 1; k <= 255; k++) begin
      tick("attack");
      check("attack_ramp", longint'(volume), 256 * k);
    end
    tick("attack_end");
    check("attack_end_vol", longint'(volume), 65535);
    check("attack_end_state", longint'(state), 2);

    // Decay to sustain, then live sustain change
    for (int k = 1; k <= 127; k++) tick("decay");
    check("decay127_vol", longint'(volume), 33023);
    tick("decay_end");
    check("decay_end_vol", longint'(volume), 32768);
    check("decay_end_state", longint'(state), 3);
    sustain_level = 16'h4000;
    tick("sustain_track");
    check("sustain_track_vol", longint'(volume), 16384);
    sustain_level = 16'h8000;
    tick("sustain_back");

    // Release to idle
    gate = 1'b0;
    tick("fall");
    check("fall_state", longint'(state), 4);
    for (int k = 1; k <= 256; k++) tick("release");
    check("release_end_vol", longint'(volume), 0);
    check("release_end_state", longint'(state), 0);
    check("release_end_active", longint'(active), 0);

    // Instant attack/decay, then retrigger during release
    attack_rate = 24'd0; decay_rate = 24'd0;
    gate = 1'b1;
    tick("rise2");
    tick("attack0");
    check("attack0_vol", longint'(volume), 65535);
    tick("decay0");
    check("decay0_vol", longint'(volume), 32768);
    gate = 1'b0;
    tick("fall2");
    for (int k = 1; k <= 128; k++) tick("release2");
    check("retrig_pre_vol", longint'(volume), 16384);
    attack_rate = 24'h010000;
    gate = 1'b1;
    tick("retrig");
    check("retrig_state", longint'(state), 1);
    check("retrig_hold_vol", longint'(volume), 16384);
    tick("retrig_step");
    check("retrig_step_vol", longint'(volume), 16640);

    // Zero release rate from sustain
    attack_rate = 24'd0;
    tick("to_decay");
    tick("to_sustain");
    release_rate = 24'd0;
    gate = 1'b0;
    tick("fall3");
    check("fall3_state", longint'(state), 4);
    tick("release0");
    check("release0_vol", longint'(volume), 0);
    check("release0_state", longint'(state), 0);

    // One-cycle gate pulse
    release_rate = 24'h008000;
    tick("idle2");
    gate = 1'b1;
    tick("pulse_rise");
    check("pulse_state1", longint'(state), 1);
    gate = 1'b0;
    tick("pulse_fall");
    check("pulse_state4", longint'(state), 4);
    check("pulse_vol", longint'(volume), 0);
    tick("pulse_idle");

    // Asynchronous reset mid-attack, gate held high across it
    attack_rate = 24'h010000;
    gate = 1'b1;
    tick("rise4");
    for (int k = 1; k <= 50; k++) tick("attack4");
    check("pre_reset_vol", longint'(volume), 12800);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("async_rst_vol", longint'(volume), 0);
    check("async_rst_state", longint'(state), 0);
    check("async_rst_active", longint'(active), 0);
    #1;
    rst = 1'b0;
    tick("post_reset_rise");
    check("post_reset_state", longint'(state), 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) gate = ~gate;
      if ($urandom_range(0, 31) == 0)
        attack_rate = ($urandom_range(0, 3) == 0) ? 24'd0 : 24'($urandom_range(1, 24'h100000));
      if ($urandom_range(0, 31) == 0)
        decay_rate = ($urandom_range(0, 3) == 0) ? 24'd0 : 24'($urandom_range(1, 24'h100000));
      if ($urandom_range(0, 31) == 0)
        release_rate = ($urandom_range(0, 3) == 0) ? 24'd0 : 24'($urandom_range(1, 24'h100000));
      if ($urandom_range(0, 15) == 0) sustain_level = 16'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        check_model("rand_rst");
        rst = 1'b0;
      end
      tick("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/env_adsr.md
# env_adsr

ADSR envelope generator that produces the per-voice volume driving a downstream oscillator (noise, square, etc.). It runs on the shared 44.1 kHz sample clock and advances one envelope step per sample. `volume` connects directly to the oscillator's signed 17-bit volume input, and `active` drives the oscillator's enable. A level-sensitive `gate` (note on/off) starts and stops the envelope.

## Interface
- No parameters; all rates and levels are runtime inputs.
- `clk`  in  1  sample clock (44.1 kHz), rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `gate`  in  1  note held; rising edge triggers or retriggers, falling edge releases.
- `attack_rate`  in  24  unsigned increment per sample in ATTACK, in units of 1/256 volume LSB; 0 means instant.
- `decay_rate`  in  24  unsigned decrement per sample in DECAY; 0 means instant.
- `sustain_level`  in  16  unsigned sustain volume; 0..65535.
- `release_rate`  in  24  unsigned decrement per sample in RELEASE; 0 means instant.
- `volume`  out  17  signed; always {1'b0, acc[23:8]}, range 0..65535.
- `active`  out  1  high whenever state is not IDLE.
- `state`  out  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.

## Operation
- Internal state: 24-bit unsigned accumulator `acc`, with FULL = 24'hFFFFFF.
- `gate_q` holds the registered copy of `gate`.
  - rise = gate & ~gate_q
  - fall = ~gate & gate_q
- Per-edge priority: rst > rise > fall > state arithmetic.
- rise, from any state: state <= ATTACK, acc unchanged. Retrigger starts from the current level, never from 0.
- fall, in ATTACK, DECAY or SUSTAIN: state <= RELEASE, acc unchanged. fall in IDLE or RELEASE is ignored.
- IDLE: acc <= 0.
- ATTACK:
  - If attack_rate==0, or acc+attack_rate ≥ FULL (25-bit sum): acc <= FULL, state <= DECAY.
  - Otherwise acc += attack_rate.
- DECAY, with T = {sustain_level, 8'h00}:
  - If decay_rate==0, or acc−decay_rate ≤ T (26-bit signed compare): acc <= T, state <= SUSTAIN.
  - Otherwise acc −= decay_rate.
  - If T > acc on entry, acc jumps up to T on the first DECAY cycle.
- SUSTAIN: acc <= {sustain_level, 8'h00} every cycle, so live sustain changes are tracked.
- RELEASE:
  - If release_rate==0, or acc ≤ release_rate: acc <= 0, state <= IDLE.
  - Otherwise acc −= release_rate.
- No wrap-around in either direction: all arithmetic saturates as above.
- Rate and level inputs are sampled every cycle. Changing them mid-phase takes effect on the next edge.

## Timing
- Reset (asynchronous, immediate): state=IDLE, acc=0, gate_q=0, volume=0, active=0.
  - rst asserted mid-envelope forces these values without waiting for a clock.
  - After release, the first rise needs a clean edge: gate held high across reset counts as a rise on the first edge after rst deasserts, because gate_q=0.
- `volume`, `active` and `state` are registered, with no combinational path from inputs.
- gate→state latency: state shows ATTACK/RELEASE after the first clk edge that samples the new gate level. Volume starts moving on the following edge.
- A one-cycle gate pulse gives ATTACK for one edge, then RELEASE on the next edge. No attack step is applied.
- Simultaneous rise with a phase-end condition: rise wins and state becomes ATTACK.

## Test plan
- Reset mid-attack: assert rst while volume=12800 (no clock edge needed) → volume=0, state=0, active=0 immediately.
- Attack ramp, attack_rate=24'h010000:
  - gate 0→1 gives state=1 after edge 1.
  - Volume = 256·k after k ATTACK edges, for k≤255.
  - ATTACK edge 256 gives volume=65535 and state=2.
- Decay, decay_rate=24'h010000, sustain_level=16'h8000, starting from FULL:
  - DECAY edge 127 gives volume=33023.
  - Edge 128 gives volume=32768 and state=3.
  - Changing sustain_level to 16'h4000 gives volume=16384 on the next edge.
- Release, release_rate=24'h008000 from volume 32768:
  - gate 1→0 gives state=4.
  - After 256 RELEASE edges: volume=0, state=0, active=0 on the same edge.
- Retrigger during release at volume=16384, attack_rate=24'h010000: gate 0→1 gives state=1 with volume 16384 held, then 16640 on the next edge. Volume never drops to 0.
- Zero rates:
  - attack_rate=0 gives volume=65535 on the first ATTACK edge.
  - release_rate=0 gives volume=0 and state=0 on the first RELEASE edge.
  - A one-cycle gate pulse gives state sequence 1→4 with no volume increase.
